// File: rtl/mole_round_scheduler.sv
// ============================================================================
//  mole_round_scheduler : Whack-A-Mole round sequencer (mole pick, timing,
//                         hit/miss judging, score/miss increment pulses)
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mole_round_scheduler #(
    parameter int          NUM_MOLES    = 8,
    parameter int          GAP_TIME     = 25_000_000,
    parameter int          UP_TIME_INIT = 50_000_000,
    parameter int          UP_TIME_MIN  = 10_000_000,
    parameter int          UP_TIME_STEP = 1_000_000,
    parameter int          ROUNDS       = 30,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] buttons,
    output logic [NUM_MOLES-1:0] mole,
    output logic                 score_inc,
    output logic                 miss_inc,
    output logic                 busy,
    output logic                 game_over,
    output logic [7:0]           round
);

    localparam int          c_IDX_W    = $clog2(NUM_MOLES);
    localparam logic [31:0] c_GAP_LOAD = 32'(GAP_TIME - 1);
    localparam logic [31:0] c_UP_INIT  = 32'(UP_TIME_INIT);
    localparam logic [31:0] c_UP_MIN   = 32'(UP_TIME_MIN);
    localparam logic [31:0] c_UP_STEP  = 32'(UP_TIME_STEP);
    localparam logic [7:0]  c_LAST_RND = 8'(ROUNDS - 1);
    localparam logic [NUM_MOLES-1:0] c_ONE = NUM_MOLES'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_UP   = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t               r_state,    w_state;
    logic [31:0]          r_timer,    w_timer;
    logic [31:0]          r_up_time,  w_up_time;
    logic [7:0]           r_round,    w_round;
    logic [15:0]          r_lfsr,     w_lfsr;
    logic [c_IDX_W-1:0]   r_last_idx, w_last_idx;
    logic [NUM_MOLES-1:0] r_btn_q;
    logic [NUM_MOLES-1:0] r_mole,     w_mole;
    logic                 r_score,    w_score;
    logic                 r_miss,     w_miss;
    logic                 r_busy,     w_busy;
    logic                 r_over,     w_over;

    logic [NUM_MOLES-1:0] w_press;
    logic [NUM_MOLES-1:0] w_target;
    logic [c_IDX_W-1:0]   w_raw_idx;
    logic [c_IDX_W-1:0]   w_new_idx;
    logic [31:0]          w_up_dec;
    logic                 w_hit;
    logic                 w_wrong;
    logic                 w_end;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_up_time  <= '0;
            r_round    <= '0;
            r_lfsr     <= LFSR_SEED;
            r_last_idx <= '0;
            r_btn_q    <= '0;
            r_mole     <= '0;
            r_score    <= 1'b0;
            r_miss     <= 1'b0;
            r_busy     <= 1'b0;
            r_over     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_timer    <= w_timer;
            r_up_time  <= w_up_time;
            r_round    <= w_round;
            r_lfsr     <= w_lfsr;
            r_last_idx <= w_last_idx;
            r_btn_q    <= buttons;
            r_mole     <= w_mole;
            r_score    <= w_score;
            r_miss     <= w_miss;
            r_busy     <= w_busy;
            r_over     <= w_over;
        end
    end

    always_comb begin
        w_lfsr    = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        w_press   = buttons & ~r_btn_q;
        w_target  = c_ONE << r_last_idx;
        w_hit     = |(w_press & w_target);
        w_wrong   = |(w_press & ~w_target);
        // Never show the same hole twice in a row: bump a repeat to the next hole.
        w_raw_idx = r_lfsr[c_IDX_W-1:0];
        w_new_idx = (w_raw_idx == r_last_idx) ? w_raw_idx + 1'b1 : w_raw_idx;
        w_up_dec  = (r_up_time >= c_UP_MIN + c_UP_STEP) ? r_up_time - c_UP_STEP : c_UP_MIN;

        w_state    = r_state;
        w_timer    = r_timer;
        w_up_time  = r_up_time;
        w_round    = r_round;
        w_last_idx = r_last_idx;
        w_mole     = r_mole;
        w_score    = 1'b0;
        w_miss     = 1'b0;
        w_busy     = r_busy;
        w_over     = r_over;
        w_end      = 1'b0;

        case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_state   = S_GAP;
                    w_timer   = c_GAP_LOAD;
                    w_up_time = c_UP_INIT;
                    w_round   = '0;
                    w_busy    = 1'b1;
                    w_over    = 1'b0;
                    w_mole    = '0;
                end
            end
            S_GAP: begin
                w_mole = '0;
                if (r_timer == '0) begin
                    w_last_idx = w_new_idx;
                    w_mole     = c_ONE << w_new_idx;
                    w_timer    = r_up_time - 32'd1;
                    w_state    = S_UP;
                end else begin
                    w_timer = r_timer - 32'd1;
                end
            end
            S_UP: begin
                if (w_hit) begin
                    w_score = 1'b1;
                    w_end   = 1'b1;
                end else if (r_timer == '0) begin
                    w_miss = 1'b1;
                    w_end  = 1'b1;
                end else begin
                    w_timer = r_timer - 32'd1;
                    w_miss  = w_wrong;
                end
                if (w_end) begin
                    w_mole    = '0;
                    w_up_time = w_up_dec;
                    if (r_round == c_LAST_RND) begin
                        w_state = S_OVER;
                        w_busy  = 1'b0;
                        w_over  = 1'b1;
                    end else begin
                        w_round = r_round + 8'd1;
                        w_timer = c_GAP_LOAD;
                        w_state = S_GAP;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign mole      = r_mole;
    assign score_inc = r_score;
    assign miss_inc  = r_miss;
    assign busy      = r_busy;
    assign game_over = r_over;
    assign round     = r_round;

endmodule

`default_nettype wire
